// File: rtl/l1_addr_gen.sv
// L1 loop-nest address sequencer: walks batch / N-group / 2x2 output tile / kx / ky / IC-group
// and issues one paired weight/activation buffer read per accepted beat.
module l1_addr_gen #(
  parameter int WEI_ADDR_W = 10,
  parameter int ACT_ADDR_W = 12,
  parameter int DIM_W      = 8,
  parameter int N_TILE     = 16,
  parameter int IC_TILE    = 3,
  parameter int OUT_TILE   = 2
)(
  input  logic                  core_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_x,
  input  logic [DIM_W-1:0]      cfg_y,
  input  logic [DIM_W-1:0]      cfg_fkx,
  input  logic [DIM_W-1:0]      cfg_fky,
  input  logic [DIM_W-1:0]      cfg_ic,
  input  logic [DIM_W-1:0]      cfg_nc,
  input  logic [DIM_W-1:0]      cfg_batch,
  input  logic [DIM_W-1:0]      cfg_stride,
  input  logic                  addr_ready,
  output logic                  addr_valid,
  output logic                  wei_read_en,
  output logic [WEI_ADDR_W-1:0] wei_read_addr,
  output logic                  act_read_en,
  output logic [ACT_ADDR_W-1:0] act_read_addr,
  output logic                  tile_first,
  output logic                  tile_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  localparam int AW  = 2*ACT_ADDR_W;
  localparam int DW1 = DIM_W+1;
  localparam logic [DIM_W-1:0] ONE  = DIM_W'(1);
  localparam logic [DIM_W-1:0] STEP = DIM_W'(OUT_TILE);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RUN, S_DONE} state_t;
  state_t state;

  logic [DIM_W-1:0] r_x, r_y, r_fkx, r_fky, r_ic, r_nc, r_b, r_s;
  logic [DIM_W-1:0] ox, oy, icg, ngn;
  logic [DIM_W-1:0] bb, ng, xx, yy, kx, ky, ig;

  logic cfg_bad;
  logic [DW1-1:0] icg_c, ng_c;
  logic ig_w, ky_w, kx_w, yy_w, xx_w, ng_w, bb_w;
  logic c_ky, c_kx, c_yy, c_xx, c_ng, c_bb, fire;

  always_comb begin
    cfg_bad = (r_x == '0) | (r_y == '0) | (r_fkx == '0) | (r_fky == '0) |
              (r_ic == '0) | (r_nc == '0) | (r_b == '0) | (r_s == '0) |
              (r_fkx > r_x) | (r_fky > r_y);
    icg_c = (DW1'(r_ic) + DW1'(IC_TILE-1)) / DW1'(IC_TILE);
    ng_c  = (DW1'(r_nc) + DW1'(N_TILE-1)) / DW1'(N_TILE);
  end

  // Each loop level wraps when it and every level inside it are at their last value.
  always_comb begin
    ig_w = (ig == icg - ONE);
    ky_w = (ky == r_fky - ONE);
    kx_w = (kx == r_fkx - ONE);
    yy_w = (DW1'(yy) + DW1'(OUT_TILE)) >= DW1'(oy);
    xx_w = (DW1'(xx) + DW1'(OUT_TILE)) >= DW1'(ox);
    ng_w = (ng == ngn - ONE);
    bb_w = (bb == r_b - ONE);
    c_ky = ig_w & ky_w;
    c_kx = c_ky & kx_w;
    c_yy = c_kx & yy_w;
    c_xx = c_yy & xx_w;
    c_ng = c_xx & ng_w;
    c_bb = c_ng & bb_w;
    fire = addr_valid & addr_ready;
  end

  assign wei_read_en   = fire;
  assign act_read_en   = fire;
  assign busy          = (state != S_IDLE);
  assign tile_first    = addr_valid & (kx == '0) & (ky == '0) & (ig == '0);
  assign tile_last     = addr_valid & c_kx;
  assign wei_read_addr = WEI_ADDR_W'(((AW'(ng)*AW'(r_fkx) + AW'(kx))*AW'(r_fky) + AW'(ky))*AW'(icg) + AW'(ig));
  assign act_read_addr = ACT_ADDR_W'(((AW'(bb)*AW'(r_x) + AW'(xx)*AW'(r_s) + AW'(kx))*AW'(r_y)
                                      + AW'(yy)*AW'(r_s) + AW'(ky))*AW'(icg) + AW'(ig));

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state <= S_IDLE;
      addr_valid <= 1'b0; done <= 1'b0; cfg_err <= 1'b0;
      r_x <= '0; r_y <= '0; r_fkx <= '0; r_fky <= '0;
      r_ic <= '0; r_nc <= '0; r_b <= '0; r_s <= '0;
      ox <= '0; oy <= '0; icg <= '0; ngn <= '0;
      bb <= '0; ng <= '0; xx <= '0; yy <= '0; kx <= '0; ky <= '0; ig <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_x <= cfg_x; r_y <= cfg_y; r_fkx <= cfg_fkx; r_fky <= cfg_fky;
            r_ic <= cfg_ic; r_nc <= cfg_nc; r_b <= cfg_batch; r_s <= cfg_stride;
            cfg_err <= 1'b0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          bb <= '0; ng <= '0; xx <= '0; yy <= '0; kx <= '0; ky <= '0; ig <= '0;
          if (cfg_bad) begin
            cfg_err <= 1'b1;
            done <= 1'b1;
            state <= S_DONE;
          end else begin
            ox  <= (r_x - r_fkx) / r_s + ONE;
            oy  <= (r_y - r_fky) / r_s + ONE;
            icg <= DIM_W'(icg_c);
            ngn <= DIM_W'(ng_c);
            addr_valid <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (fire) begin
            ig <= ig_w ? '0 : ig + ONE;
            if (ig_w) ky <= c_ky ? '0 : ky + ONE;
            if (c_ky) kx <= c_kx ? '0 : kx + ONE;
            if (c_kx) yy <= c_yy ? '0 : yy + STEP;
            if (c_yy) xx <= c_xx ? '0 : xx + STEP;
            if (c_xx) ng <= c_ng ? '0 : ng + ONE;
            if (c_ng) bb <= c_bb ? '0 : bb + ONE;
            if (c_bb) begin
              addr_valid <= 1'b0;
              done <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        default: begin
          done <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
